// File: rtl/spi_target.sv
// SPI mode-3 responder with every pin oversampled on clk_in. It captures MSB-first
// frames from MOSI and streams back a response word that is snapshotted at CS fall.
module spi_target #(
    parameter int unsigned SIZE      = 40,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            sck_in,
    input  logic            mosi_in,
    input  logic            cs_n_in,
    input  logic [SIZE-1:0] data_in,
    output logic            miso_out,
    output logic            miso_oe_out,
    output logic [SIZE-1:0] r_data_out,
    output logic            r_valid_out,
    output logic            r_busy_out,
    output logic            r_error_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sck_meta, r_sck_sync, r_sck_prev;
    logic                  r_cs_meta, r_cs_sync, r_cs_prev;
    logic                  r_mosi_meta, r_mosi_sync;
    logic [1:0]            r_live;
    logic                  r_armed;
    logic [SIZE-1:0]       r_tx, r_rx;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_overrun;

    logic                  w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
    logic [SIZE-1:0]       w_tx_nxt, w_rx_nxt, w_data_nxt, w_tx_shifted, w_rx_shifted;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt, w_cnt_inc;
    logic                  w_overrun_nxt, w_miso_nxt, w_oe_nxt, w_valid_nxt;
    logic                  w_busy_nxt, w_error_nxt;

    // Pin synchronisers plus a third copy for edge detection
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_sck_meta  <= 1'b1;
            r_sck_sync  <= 1'b1;
            r_sck_prev  <= 1'b1;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_live      <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sck_meta  <= sck_in;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_cs_meta   <= cs_n_in;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_mosi_meta <= mosi_in;
            r_mosi_sync <= r_mosi_meta;
            r_live      <= {r_live[0], 1'b1};
            // Arm only once CS has really been seen high after reset
            r_armed     <= r_armed | (r_live[1] & r_cs_sync);
        end
    end

    assign w_sck_rise   = r_sck_sync & ~r_sck_prev;
    assign w_sck_fall   = ~r_sck_sync & r_sck_prev;
    assign w_cs_rise    = r_cs_sync & ~r_cs_prev;
    assign w_cs_fall    = ~r_cs_sync & r_cs_prev;
    assign w_tx_shifted = r_tx << 1;
    assign w_rx_shifted = (r_rx << 1) | SIZE'(r_mosi_sync);
    assign w_cnt_inc    = r_cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_cnt_nxt     = r_cnt;
        w_overrun_nxt = r_overrun;
        w_miso_nxt    = miso_out;
        w_oe_nxt      = miso_oe_out;
        w_data_nxt    = r_data_out;
        w_busy_nxt    = r_busy_out;
        w_valid_nxt   = 1'b0;
        w_error_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_tx_nxt      = data_in;
                    w_miso_nxt    = data_in[SIZE-1];
                    w_rx_nxt      = '0;
                    w_cnt_nxt     = '0;
                    w_overrun_nxt = 1'b0;
                    w_oe_nxt      = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_error_nxt = 1'b1;
                    w_oe_nxt    = 1'b0;
                    w_miso_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (w_sck_rise) begin
                    w_rx_nxt  = w_rx_shifted;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_WIDTH'(SIZE)) begin
                        w_data_nxt  = w_rx_shifted;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = DONE;
                    end
                end else if (w_sck_fall && r_cnt != '0) begin
                    // Falls before the first sample keep the preloaded MSB
                    w_tx_nxt   = w_tx_shifted;
                    w_miso_nxt = w_tx_shifted[SIZE-1];
                end
            end
            DONE: begin
                if (w_cs_rise) begin
                    w_error_nxt   = r_overrun;
                    w_overrun_nxt = 1'b0;
                    w_oe_nxt      = 1'b0;
                    w_miso_nxt    = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = IDLE;
                end else begin
                    if (w_sck_rise) w_overrun_nxt = 1'b1;
                    if (w_sck_fall) begin
                        w_tx_nxt   = w_tx_shifted;
                        w_miso_nxt = w_tx_shifted[SIZE-1];
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_tx        <= '0;
            r_rx        <= '0;
            r_cnt       <= '0;
            r_overrun   <= 1'b0;
            miso_out    <= 1'b0;
            miso_oe_out <= 1'b0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_busy_out  <= 1'b0;
            r_error_out <= 1'b0;
        end else begin
            r_tx        <= w_tx_nxt;
            r_rx        <= w_rx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_overrun   <= w_overrun_nxt;
            miso_out    <= w_miso_nxt;
            miso_oe_out <= w_oe_nxt;
            r_data_out  <= w_data_nxt;
            r_valid_out <= w_valid_nxt;
            r_busy_out  <= w_busy_nxt;
            r_error_out <= w_error_nxt;
        end
    end

endmodule
